// File: rtl/hilo_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg: shared definitions for the HI/LO multiply/divide controller.
//   WIDTH       datapath width (HI/LO width; products are 2*WIDTH)
//   OP_W        width of the MD op code presented by EX
//   md_op_e     MD op codes driven by EX
//   md_state_e  controller FSM states
// -----------------------------------------------------------------------------
package md_pkg;

  localparam int WIDTH = 32;
  localparam int OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    MD_NOP   = 3'd0,
    MD_DIV   = 3'd1,
    MD_DIVU  = 3'd2,
    MD_MULT  = 3'd3,
    MD_MULTU = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } md_state_e;

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// hilo_div_ctrl_if: start/busy handshake between the HI/LO controller and the
// iterative divider.
//   div_start        one-cycle launch pulse (controller -> divider)
//   div_dividend     operand, held stable from start until done
//   div_divisor      operand, held stable from start until done
//   div_is_unsigned  1 for DIVU
//   div_quotient     result (divider -> controller)
//   div_remainder    result (divider -> controller)
//   div_busy         high the cycle after start until the result is ready
// Modports: master = controller side, slave = divider side.
// -----------------------------------------------------------------------------
interface hilo_div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_is_unsigned;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             div_busy;

  modport master (
    output div_start, div_dividend, div_divisor, div_is_unsigned,
    input  div_quotient, div_remainder, div_busy
  );

  modport slave (
    input  div_start, div_dividend, div_divisor, div_is_unsigned,
    output div_quotient, div_remainder, div_busy
  );
endinterface

// File: rtl/hilo_div_ctrl_hilo_regs.sv
// -----------------------------------------------------------------------------
// hilo_regs: architectural HI/LO registers with independent write ports and
// the MFHI/MFLO read mux. When i_byp_en is high the read mux returns the
// bypass values (divider result being written this cycle) instead of the
// registered contents.
//   i_hi_we/i_hi_wdata, i_lo_we/i_lo_wdata   write ports
//   i_byp_en, i_byp_hi, i_byp_lo              read bypass
//   i_mf_sel                                  0=LO, 1=HI
//   o_mf_data                                 selected value
//   o_hi, o_lo                                registered HI/LO
// -----------------------------------------------------------------------------
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_hi_we,
  input  logic [WIDTH-1:0] i_hi_wdata,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_lo_wdata,
  input  logic             i_byp_en,
  input  logic [WIDTH-1:0] i_byp_hi,
  input  logic [WIDTH-1:0] i_byp_lo,
  input  logic             i_mf_sel,
  output logic [WIDTH-1:0] o_mf_data,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_we) r_hi <= i_hi_wdata;
      if (i_lo_we) r_lo <= i_lo_wdata;
    end
  end

  assign o_hi      = r_hi;
  assign o_lo      = r_lo;
  assign o_mf_data = i_byp_en ? (i_mf_sel ? i_byp_hi : i_byp_lo)
                              : (i_mf_sel ? r_hi     : r_lo);

endmodule

// File: rtl/hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_div_ctrl: owns HI/LO and executes MD ops from EX.
//   MULT/MULTU and MTHI/MTLO complete at the accepting edge.
//   DIV/DIVU latch operands, pulse div_start for one cycle, then wait for the
//   divider's busy flag to fall and write HI=remainder, LO=quotient.
//   EX is stalled while a divide is pending and EX presents an MD op or MF read.
// Ports:
//   clk, resetn (async, active low)
//   i_md_valid, i_md_op, i_rs, i_rt   MD op from EX
//   i_mf_req, i_mf_sel, o_mf_data     MFHI/MFLO read
//   i_flush                           cancel presented/pending MD op
//   o_stall                           hold EX and earlier stages
//   o_hi, o_lo                        architectural HI/LO
//   div_if (master)                   divider start/busy handshake
// Configuration macro: HILO_BYPASS_EN -- when defined, an MF read pending on
// a divide is served from the divider result in the completion cycle.
// -----------------------------------------------------------------------------
module hilo_div_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = md_pkg::WIDTH,
  parameter int OP_W  = md_pkg::OP_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_md_valid,
  input  logic [OP_W-1:0]   i_md_op,
  input  logic [WIDTH-1:0]  i_rs,
  input  logic [WIDTH-1:0]  i_rt,
  input  logic              i_mf_req,
  input  logic              i_mf_sel,
  input  logic              i_flush,
  output logic [WIDTH-1:0]  o_mf_data,
  output logic              o_stall,
  output logic [WIDTH-1:0]  o_hi,
  output logic [WIDTH-1:0]  o_lo,
  hilo_div_ctrl_if.master   div_if
);

  md_state_e        r_state;
  logic             r_div_start;
  logic             r_is_unsigned;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;

  md_op_e           w_op;
  logic             w_accept;
  logic             w_is_div;
  logic             w_div_done;
  logic             w_byp_en;
  logic             w_mul_signed;
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_hi_we;
  logic             w_lo_we;
  logic [WIDTH-1:0] w_hi_wdata;
  logic [WIDTH-1:0] w_lo_wdata;

  assign w_op       = md_op_e'(i_md_op);
  assign w_accept   = (r_state == ST_IDLE) && i_md_valid && !i_flush;
  assign w_is_div   = (w_op == MD_DIV) || (w_op == MD_DIVU);
  // Busy is only meaningful from WAIT onward; the divider raises it the
  // cycle after start, so LAUNCH never looks at it.
  assign w_div_done = (r_state == ST_WAIT) && !div_if.div_busy && !i_flush;

  // Full 2*WIDTH product of the extended operands equals the signed (or
  // unsigned) product, so one multiplier serves both MULT and MULTU.
  assign w_mul_signed = (w_op == MD_MULT);
  assign w_mul_a = w_mul_signed ? {{WIDTH{i_rs[WIDTH-1]}}, i_rs} : {{WIDTH{1'b0}}, i_rs};
  assign w_mul_b = w_mul_signed ? {{WIDTH{i_rt[WIDTH-1]}}, i_rt} : {{WIDTH{1'b0}}, i_rt};
  assign w_prod  = w_mul_a * w_mul_b;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_div_start   <= 1'b0;
      r_is_unsigned <= 1'b0;
      r_dividend    <= '0;
      r_divisor     <= '0;
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_div) begin
            r_dividend    <= i_rs;
            r_divisor     <= i_rt;
            r_is_unsigned <= (w_op == MD_DIVU);
            r_div_start   <= 1'b1;
            r_state       <= ST_LAUNCH;
          end
        end
        // The start pulse is already out; a flush here simply abandons it and
        // the next start will override the still-running divider.
        ST_LAUNCH: r_state <= i_flush ? ST_IDLE : ST_WAIT;
        ST_WAIT: begin
          if (i_flush || !div_if.div_busy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_hi_we    = 1'b0;
    w_lo_we    = 1'b0;
    w_hi_wdata = '0;
    w_lo_wdata = '0;
    if (w_accept) begin
      case (w_op)
        MD_MULT, MD_MULTU: begin
          w_hi_we    = 1'b1;
          w_lo_we    = 1'b1;
          w_hi_wdata = w_prod[2*WIDTH-1:WIDTH];
          w_lo_wdata = w_prod[WIDTH-1:0];
        end
        MD_MTHI: begin
          w_hi_we    = 1'b1;
          w_hi_wdata = i_rs;
        end
        MD_MTLO: begin
          w_lo_we    = 1'b1;
          w_lo_wdata = i_rs;
        end
        default: ;
      endcase
    end else if (w_div_done) begin
      w_hi_we    = 1'b1;
      w_lo_we    = 1'b1;
      w_hi_wdata = div_if.div_remainder;
      w_lo_wdata = div_if.div_quotient;
    end
  end

`ifdef HILO_BYPASS_EN
  assign w_byp_en = w_div_done;
`else
  assign w_byp_en = 1'b0;
`endif

  // An MD op still stalls in the completion cycle: the FSM is not in IDLE yet,
  // so it could not be accepted. Only the MF read can be released early.
  assign o_stall = (r_state != ST_IDLE) && (i_md_valid || (i_mf_req && !w_byp_en));

  assign div_if.div_start       = r_div_start;
  assign div_if.div_dividend    = r_dividend;
  assign div_if.div_divisor     = r_divisor;
  assign div_if.div_is_unsigned = r_is_unsigned;

  hilo_regs #(.WIDTH(WIDTH)) u_hilo_regs (
    .clk        (clk),
    .resetn     (resetn),
    .i_hi_we    (w_hi_we),
    .i_hi_wdata (w_hi_wdata),
    .i_lo_we    (w_lo_we),
    .i_lo_wdata (w_lo_wdata),
    .i_byp_en   (w_byp_en),
    .i_byp_hi   (div_if.div_remainder),
    .i_byp_lo   (div_if.div_quotient),
    .i_mf_sel   (i_mf_sel),
    .o_mf_data  (o_mf_data),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_div_ctrl: bench for hilo_div_ctrl paired with a behavioural 32-cycle
// divider. MF read results are scoreboarded against a HI/LO reference model
// updated in program order; directed timing checks cover start/busy/stall.
// -----------------------------------------------------------------------------
module tb_hilo_div_ctrl;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         i_md_valid = 1'b0;
  logic [2:0]   i_md_op = 3'd0;
  logic [W-1:0] i_rs = '0;
  logic [W-1:0] i_rt = '0;
  logic         i_mf_req = 1'b0;
  logic         i_mf_sel = 1'b0;
  logic         i_flush = 1'b0;
  logic [W-1:0] o_mf_data;
  logic         o_stall;
  logic [W-1:0] o_hi;
  logic [W-1:0] o_lo;

  hilo_div_ctrl_if #(.WIDTH(W)) div_if ();

  hilo_div_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_md_valid (i_md_valid),
    .i_md_op    (i_md_op),
    .i_rs       (i_rs),
    .i_rt       (i_rt),
    .i_mf_req   (i_mf_req),
    .i_mf_sel   (i_mf_sel),
    .i_flush    (i_flush),
    .o_mf_data  (o_mf_data),
    .o_stall    (o_stall),
    .o_hi       (o_hi),
    .o_lo       (o_lo),
    .div_if     (div_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] ref_hi = '0;
  logic [W-1:0] ref_lo = '0;
  logic [W-1:0] sb_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event did not occur (got none, required one) at %0t", name, $time);
  endtask

  // Divider semantics: MIPS truncating division; divide-by-zero yields
  // quotient all-ones, remainder = dividend.
  function automatic logic [2*W-1:0] div_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic uns);
    longint sa, sb;
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (uns) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end
    return {r, q};
  endfunction

  function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
    longint p;
    longint unsigned u;
    if (sgn) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    u = {32'd0, a} * {32'd0, b};
    return u;
  endfunction

  // ---------------- behavioural divider (slave side) ----------------
  logic         dv_busy;
  int           dv_cnt;
  logic [W-1:0] dv_q, dv_r;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dv_busy <= 1'b0;
      dv_cnt  <= 0;
      dv_q    <= '0;
      dv_r    <= '0;
    end else if (div_if.div_start) begin
      dv_busy <= 1'b1;
      dv_cnt  <= 31;
      {dv_r, dv_q} <= div_ref(div_if.div_dividend, div_if.div_divisor, div_if.div_is_unsigned);
    end else if (dv_busy) begin
      if (dv_cnt == 0) dv_busy <= 1'b0;
      else dv_cnt <= dv_cnt - 1;
    end
  end

  // Results are garbage while busy, so an early write is visible.
  assign div_if.div_busy      = dv_busy;
  assign div_if.div_quotient  = dv_busy ? 32'hDEAD_BEEF : dv_q;
  assign div_if.div_remainder = dv_busy ? 32'hBAAD_F00D : dv_r;

  // ---------------- reference model ----------------
  task automatic model_apply(input md_op_e op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    case (op)
      MD_DIV:   {ref_hi, ref_lo} = div_ref(rs, rt, 1'b0);
      MD_DIVU:  {ref_hi, ref_lo} = div_ref(rs, rt, 1'b1);
      MD_MULT:  {ref_hi, ref_lo} = mul_ref(rs, rt, 1'b1);
      MD_MULTU: {ref_hi, ref_lo} = mul_ref(rs, rt, 1'b0);
      MD_MTHI:  ref_hi = rs;
      MD_MTLO:  ref_lo = rs;
      default: ;
    endcase
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (resetn && i_mf_req && !o_stall) begin
      if (sb_q.size() == 0) fail_now("mf_expected_entry");
      else check("mf_data", o_mf_data, sb_q.pop_front());
    end
  end

  // ---------------- drivers (enter and leave at posedge+1) ----------------
  task automatic wait_nostall(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = !o_stall;
    end
    if (!ok) fail_now(name);
  endtask

  task automatic issue_md(input md_op_e op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    i_md_valid = 1'b1;
    i_md_op    = op;
    i_rs       = rs;
    i_rt       = rt;
    wait_nostall("md_accept_timeout");
    model_apply(op, rs, rt);
    @(posedge clk); #1;
    i_md_valid = 1'b0;
  endtask

  task automatic issue_mf(input logic sel);
    i_mf_req = 1'b1;
    i_mf_sel = sel;
    sb_q.push_back(sel ? ref_hi : ref_lo);
    wait_nostall("mf_timeout");
    @(posedge clk); #1;
    i_mf_req = 1'b0;
  endtask

  // Presents a divide in IDLE (cycle T) and returns at T+1.
  task automatic start_div(input md_op_e op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                           input bit apply);
    i_md_valid = 1'b1;
    i_md_op    = op;
    i_rs       = rs;
    i_rt       = rt;
    @(negedge clk);
    check("div_accept_nostall", 32'(o_stall), 32'd0);
    if (apply) model_apply(op, rs, rt);
    @(posedge clk); #1;
    i_md_valid = 1'b0;
  endtask

  initial begin
    int starts;
    int rel;
    logic [W-1:0] hold_hi, hold_lo, rs, rt;

    // Reset state.
    i_mf_req = 1'b1;
    #2;
    check("rst_hi", o_hi, '0);
    check("rst_lo", o_lo, '0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_start", 32'(div_if.div_start), 32'd0);
    check("rst_dividend", div_if.div_dividend, '0);
    check("rst_divisor", div_if.div_divisor, '0);
    i_mf_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // DIVU 100/7: start only at T+1, busy from T+2, result at T+35.
    start_div(MD_DIVU, 32'd100, 32'd7, 1'b1);
    check("divu_start_t1", 32'(div_if.div_start), 32'd1);
    check("divu_dividend", div_if.div_dividend, 32'd100);
    check("divu_divisor", div_if.div_divisor, 32'd7);
    check("divu_is_unsigned", 32'(div_if.div_is_unsigned), 32'd1);
    starts = 0;
    for (int c = 2; c <= 35; c++) begin
      @(posedge clk); #1;
      if (div_if.div_start) starts++;
      if (c == 2) check("divu_busy_t2", 32'(div_if.div_busy), 32'd1);
      if (c == 34) check("divu_lo_t34_old", o_lo, 32'd0);
    end
    check("divu_single_start", 32'(starts), 32'd0);
    check("divu_lo_t35", o_lo, 32'd14);
    check("divu_hi_t35", o_hi, 32'd2);
    issue_mf(1'b0);
    issue_mf(1'b1);

    // Signed DIV with MFLO presented at T+3.
    start_div(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check("div_signed_flag", 32'(div_if.div_is_unsigned), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_mf_req = 1'b1;
    i_mf_sel = 1'b0;
    sb_q.push_back(ref_lo);
    rel = -1;
    for (int c = 3; c <= 40 && rel < 0; c++) begin
      @(negedge clk);
      if (!o_stall) rel = c;
    end
    check("mflo_stall_until_done", 32'(rel == 34 || rel == 35), 32'd1);
    @(posedge clk); #1;
    i_mf_req = 1'b0;
    check("div_lo", o_lo, 32'hFFFF_FFFD);
    issue_mf(1'b1);

    // MULT / MULTU.
    issue_md(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    check("mult_hi", o_hi, 32'hFFFF_FFFF);
    check("mult_lo", o_lo, 32'hFFFF_FFFE);
    issue_md(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_hi", o_hi, 32'd1);
    check("multu_lo", o_lo, 32'hFFFF_FFFE);

    // Flush at T+10 of a divide; MTLO accepted at T+11.
    hold_hi = ref_hi;
    start_div(MD_DIV, 32'd1234, 32'd5, 1'b0);
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk); #1;
    end
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush    = 1'b0;
    i_md_valid = 1'b1;
    i_md_op    = MD_MTLO;
    i_rs       = 32'd5;
    @(negedge clk);
    check("mtlo_after_flush_nostall", 32'(o_stall), 32'd0);
    @(posedge clk); #1;
    i_md_valid = 1'b0;
    ref_lo = 32'd5;
    check("flush_lo_mtlo", o_lo, 32'd5);
    check("flush_hi_kept", o_hi, hold_hi);
    repeat (30) @(posedge clk);
    #1;
    check("flush_no_late_hi", o_hi, hold_hi);
    check("flush_no_late_lo", o_lo, 32'd5);

    // Reset at T+20 of a divide.
    start_div(MD_DIVU, 32'd1000, 32'd7, 1'b0);
    for (int c = 2; c <= 20; c++) begin
      @(posedge clk); #1;
    end
    i_mf_req = 1'b1;
    i_mf_sel = 1'b0;
    #1;
    check("stall_mid_div", 32'(o_stall), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_hi", o_hi, '0);
    check("midrst_lo", o_lo, '0);
    check("midrst_stall", 32'(o_stall), 32'd0);
    check("midrst_start", 32'(div_if.div_start), 32'd0);
    i_mf_req = 1'b0;
    ref_hi = '0;
    ref_lo = '0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    issue_md(MD_DIVU, 32'd9, 32'd3);
    issue_mf(1'b0);
    issue_mf(1'b1);

    // Randomized op mix with interleaved MF reads.
    for (int i = 0; i < 150; i++) begin
      rs = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       rt = '0;
        1:       rt = $urandom_range(1, 16);
        2:       rt = '1;
        default: rt = $urandom;
      endcase
      issue_md(md_op_e'($urandom_range(0, 6)), rs, rt);
      repeat ($urandom_range(0, 2)) issue_mf(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    issue_mf(1'b0);
    issue_mf(1'b1);
    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
